// File: rtl/lcd_nibble_writer_if.sv
// Byte write port between the ALU and the character-LCD nibble writer.
`timescale 1ns/1ps
interface lcd_nibble_writer_if;
  logic       iWrite;
  logic [7:0] iData;
  logic       iRS;
  logic       oReady;

  modport master (
    output iWrite,
    output iData,
    output iRS,
    input  oReady
  );

  modport slave (
    input  iWrite,
    input  iData,
    input  iRS,
    output oReady
  );
endinterface

// File: rtl/lcd_nibble_writer.sv
// 4-bit character LCD writer: power-up init, config bytes, then
// one byte per handshake sent as two E-strobed nibbles.
`timescale 1ns/1ps
module lcd_nibble_writer #(
  parameter int P_POWERUP = 750000,
  parameter int P_INIT1   = 205000,
  parameter int P_INIT2   = 5000,
  parameter int P_SHORT   = 2000,
  parameter int P_CLEAR   = 82000,
  parameter int P_NIBGAP  = 50,
  parameter int P_SETUP   = 2,
  parameter int P_EN      = 12,
  parameter int CNT_W     = 20
) (
  input  logic                Clock,
  input  logic                Reset,
  lcd_nibble_writer_if.slave  bus,
  output logic                oLCD_Enabled,
  output logic                oLCD_RegisterSelect,
  output logic                oLCD_StrataFlashControl,
  output logic                oLCD_ReadWrite,
  output logic [3:0]          oLCD_Data
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t C_PWR   = CNT_W'(P_POWERUP - 1);
  localparam cnt_t C_INIT1 = CNT_W'(P_INIT1 - 1);
  localparam cnt_t C_INIT2 = CNT_W'(P_INIT2 - 1);
  localparam cnt_t C_SHORT = CNT_W'(P_SHORT - 1);
  localparam cnt_t C_CLEAR = CNT_W'(P_CLEAR - 1);
  localparam cnt_t C_GAP   = CNT_W'(P_NIBGAP - 1);
  localparam cnt_t C_SET   = CNT_W'(P_SETUP - 1);
  localparam cnt_t C_EN    = CNT_W'(P_EN - 1);

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_INITW, S_IDLE,
    S_HI, S_GAP, S_LO, S_WAIT
  } state_t;

  typedef enum logic [1:0] {
    PH_LD, PH_SET, PH_EN, PH_HLD
  } ph_t;

  state_t     state_q;
  ph_t        ph_q;
  cnt_t       cnt_q;
  logic [3:0] step_q;
  logic [7:0] byte_q;
  logic       rs_q;
  logic       ready_q;
  logic       en_q;
  logic       rso_q;
  logic [3:0] dat_q;

  logic       cnt_z;
  logic [3:0] ld_nib;
  logic       ld_rs;
  logic [7:0] cfg_byte;
  cnt_t       init_wait;
  cnt_t       byte_wait;

  always_comb begin
    cnt_z  = (cnt_q == '0);
    ld_nib = byte_q[7:4];
    ld_rs  = rs_q;
    if (state_q == S_INIT) begin
      ld_nib = (step_q == 4'd3) ? 4'h2 : 4'h3;
      ld_rs  = 1'b0;
    end
    unique case (step_q[1:0])
      2'd0:    cfg_byte = 8'h28;
      2'd1:    cfg_byte = 8'h06;
      2'd2:    cfg_byte = 8'h0C;
      default: cfg_byte = 8'h01;
    endcase
    unique case (step_q[1:0])
      2'd0:    init_wait = C_INIT1;
      2'd1:    init_wait = C_INIT2;
      default: init_wait = C_SHORT;
    endcase
    // clear and home are the slow commands
    if (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02))
      byte_wait = C_CLEAR;
    else
      byte_wait = C_SHORT;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_PWR;
      ph_q    <= PH_LD;
      cnt_q   <= '0;
      step_q  <= '0;
      byte_q  <= '0;
      rs_q    <= 1'b0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      rso_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      unique case (state_q)
        // counts up from the cleared reset value
        S_PWR: begin
          if (cnt_q == C_PWR) begin
            cnt_q   <= '0;
            state_q <= S_INIT;
            ph_q    <= PH_LD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_INIT, S_HI, S_LO: begin
          unique case (ph_q)
            PH_LD: begin
              dat_q <= ld_nib;
              rso_q <= ld_rs;
              ph_q  <= PH_SET;
              cnt_q <= C_SET;
            end
            PH_SET: begin
              if (cnt_z) begin
                en_q  <= 1'b1;
                ph_q  <= PH_EN;
                cnt_q <= C_EN;
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end
            PH_EN: begin
              if (cnt_z) begin
                en_q  <= 1'b0;
                ph_q  <= PH_HLD;
                cnt_q <= C_SET;
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end
            default: begin
              if (cnt_z) begin
                unique case (state_q)
                  S_INIT: begin
                    state_q <= S_INITW;
                    cnt_q   <= init_wait;
                  end
                  S_HI: begin
                    state_q <= S_GAP;
                    cnt_q   <= C_GAP;
                  end
                  default: begin
                    state_q <= S_WAIT;
                    cnt_q   <= byte_wait;
                  end
                endcase
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end
          endcase
        end
        S_INITW: begin
          if (cnt_z) begin
            step_q <= step_q + 4'd1;
            if (step_q == 4'd3) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_INIT;
              ph_q    <= PH_LD;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_IDLE: begin
          if (step_q < 4'd8) begin
            byte_q  <= cfg_byte;
            rs_q    <= 1'b0;
            step_q  <= step_q + 4'd1;
            state_q <= S_HI;
            ph_q    <= PH_LD;
          end else if (bus.iWrite && ready_q) begin
            byte_q  <= bus.iData;
            rs_q    <= bus.iRS;
            ready_q <= 1'b0;
            state_q <= S_HI;
            ph_q    <= PH_LD;
          end
        end
        // lower nibble goes out directly so the gap is exact
        S_GAP: begin
          if (cnt_z) begin
            dat_q   <= byte_q[3:0];
            state_q <= S_LO;
            ph_q    <= PH_SET;
            cnt_q   <= C_SET;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          if (cnt_z) begin
            state_q <= S_IDLE;
            ready_q <= (step_q == 4'd8);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.oReady              = ready_q;
  assign oLCD_Enabled            = en_q;
  assign oLCD_RegisterSelect     = rso_q;
  assign oLCD_Data               = dat_q;
  assign oLCD_StrataFlashControl = 1'b1;
  assign oLCD_ReadWrite          = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Bench for lcd_nibble_writer: scoreboarded E strobes, timing checks,
// handshake corner cases and asynchronous reset.
`timescale 1ns/1ps
module tb_lcd_nibble_writer;

  localparam int SETUP = 1;
  localparam int EN    = 2;
  localparam int SHORT = 4;
  localparam int CLEAR = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e, rs, sf, rw;
  logic [3:0] d;

  always #5 clk = ~clk;

  lcd_nibble_writer_if bus ();

  lcd_nibble_writer #(
    .P_POWERUP(20), .P_INIT1(10), .P_INIT2(6),
    .P_SHORT(SHORT), .P_CLEAR(CLEAR), .P_NIBGAP(3),
    .P_SETUP(SETUP), .P_EN(EN), .CNT_W(8)
  ) dut (
    .Clock                  (clk),
    .Reset                  (rst),
    .bus                    (bus),
    .oLCD_Enabled           (e),
    .oLCD_RegisterSelect    (rs),
    .oLCD_StrataFlashControl(sf),
    .oLCD_ReadWrite         (rw),
    .oLCD_Data              (d)
  );

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         wait_len;
  } vec_t;

  vec_t       tbl [6];
  logic [4:0] sbq [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         t_fall = 0;
  int         t_acc = 0;
  int         width = 0;
  bit         pe = 1'b0;
  logic [4:0] cap = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // strobe monitor: scoreboard pop on each E rise
  always @(negedge clk) begin
    if (rst) begin
      pe = 1'b0;
    end else begin
      if (e && !pe) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got %0h expected none", {rs, d});
        end else begin
          chk("strobe_rs_data", {27'd0, rs, d}, {27'd0, sbq.pop_front()});
        end
        width = 1;
        cap   = {rs, d};
      end else if (e && pe) begin
        width++;
        chk("data_stable_E", {27'd0, rs, d}, {27'd0, cap});
      end else if (!e && pe) begin
        chk("E_width", width, EN);
        t_fall = cyc;
      end
      pe = e;
    end
  end

  task automatic push_byte(input logic [7:0] b, input logic r);
    sbq.push_back({r, b[7:4]});
    sbq.push_back({r, b[3:0]});
  endtask

  task automatic push_init();
    sbq.push_back(5'h03);
    sbq.push_back(5'h03);
    sbq.push_back(5'h03);
    sbq.push_back(5'h02);
    push_byte(8'h28, 1'b0);
    push_byte(8'h06, 1'b0);
    push_byte(8'h0C, 1'b0);
    push_byte(8'h01, 1'b0);
  endtask

  task automatic wait_ready(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.oReady) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_rise(output int t);
    bit ok = 1'b0;
    t = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (e) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
    chk("E_rise_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic r);
    wait_ready("ready_before_write");
    bus.iWrite = 1'b1;
    bus.iData  = b;
    bus.iRS    = r;
    push_byte(b, r);
    @(negedge clk);
    t_acc      = cyc;
    bus.iWrite = 1'b0;
    chk("ready_drop", {31'd0, bus.oReady}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int tr;
    int early;
    int tf;
    int seen;
    bit pd;

    tbl[0] = '{8'h41, 1'b1, SHORT};
    tbl[1] = '{8'h01, 1'b0, CLEAR};
    tbl[2] = '{8'h02, 1'b0, CLEAR};
    tbl[3] = '{8'h01, 1'b1, SHORT};
    tbl[4] = '{8'h03, 1'b0, SHORT};
    tbl[5] = '{8'hA5, 1'b1, SHORT};

    bus.iWrite = 1'b0;
    bus.iData  = 8'h00;
    bus.iRS    = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_E",     {31'd0, e},         32'd0);
    chk("rst_RS",    {31'd0, rs},        32'd0);
    chk("rst_Data",  {28'd0, d},         32'd0);
    chk("rst_RW",    {31'd0, rw},        32'd0);
    chk("rst_SF",    {31'd0, sf},        32'd1);
    chk("rst_Ready", {31'd0, bus.oReady}, 32'd0);

    push_init();
    rst   = 1'b0;
    early = 0;
    repeat (20) begin
      @(negedge clk);
      if (e) early++;
    end
    chk("no_early_E", early, 0);
    wait_ready("init_ready");
    chk("init_ready_delay", cyc - t_fall, SETUP + CLEAR);
    chk("init_queue_empty", sbq.size(), 0);

    foreach (tbl[k]) begin
      write_byte(tbl[k].data, tbl[k].rs);
      wait_rise(tr);
      chk("accept_to_E", tr - t_acc, 1 + SETUP);
      wait_ready("byte_ready");
      chk("post_byte_wait", cyc - t_fall, SETUP + tbl[k].wait_len);
      chk("byte_queue_empty", sbq.size(), 0);
    end

    write_byte(8'h42, 1'b1);
    repeat (3) @(negedge clk);
    bus.iWrite = 1'b1;
    bus.iData  = 8'h55;
    bus.iRS    = 1'b0;
    @(negedge clk);
    bus.iWrite = 1'b0;
    wait_ready("ignore_ready");
    repeat (30) @(negedge clk);
    chk("ignored_write_queue", sbq.size(), 0);
    chk("ignored_write_ready", {31'd0, bus.oReady}, 32'd1);

    bus.iWrite = 1'b1;
    bus.iData  = 8'h30;
    bus.iRS    = 1'b1;
    push_byte(8'h30, 1'b1);
    push_byte(8'h31, 1'b1);
    @(negedge clk);
    chk("b2b_first_accept", {31'd0, bus.oReady}, 32'd0);
    bus.iData = 8'h31;
    wait_ready("b2b_ready");
    tf = t_fall;
    @(negedge clk);
    bus.iWrite = 1'b0;
    chk("b2b_second_accept", {31'd0, bus.oReady}, 32'd0);
    wait_rise(tr);
    chk("b2b_fall_to_rise", tr - tf, SETUP + SHORT + 1 + 1 + SETUP);
    wait_ready("b2b_done");
    chk("b2b_queue_empty", sbq.size(), 0);

    write_byte(8'h41, 1'b1);
    seen = 0;
    pd   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (e && !pd) seen++;
      pd = e;
      if (seen == 2) break;
    end
    chk("lo_strobe_reached", seen, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_E",     {31'd0, e},         32'd0);
    chk("async_rst_Ready", {31'd0, bus.oReady}, 32'd0);
    sbq.delete();
    push_init();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready("reinit_ready");
    chk("reinit_queue_empty", sbq.size(), 0);
    chk("final_SF", {31'd0, sf}, 32'd1);
    chk("final_RW", {31'd0, rw}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
